cfg_chain_loader: RTL

Sequencer that pushes the SPI-programmed analog configuration out to the on-chip DAC and bias shift chains. On a start pulse it walks the register-file shadow copies in order: DAC config halfwords at byte addresses 20, 22, … and bias words at 112–124. It fetches each through a single-cycle read port, serializes the value MSB-first on a shared sdata/sclk bus, and strobes the matching load enable. It sits in digital_top between the SPI register file and the analog configuration chains.

---
 rtl/cfg_chain_loader.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: pushes the SPI-programmed analog configuration into the
// DAC and bias shift chains. Each item is fetched from the register-file shadow
// copy and shifted MSB-first on sdata/sclk. DAC items are strobed one at a time.
// The bias words share one chain and get a single load strobe at the end.
module cfg_chain_loader #(
    parameter int NUM_DACS = 10,
    parameter int DAC_W    = 12,
    parameter int NUM_BIAS = 4,
    parameter int BIAS_W   = 24,
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DIV_W-1:0]    div,
    output logic                rf_re,
    output logic [6:0]          rf_addr,
    input  logic [31:0]         rf_rdata,
    output logic                sdata,
    output logic                sclk,
    output logic [NUM_DACS-1:0] dac_ld,
    output logic                bias_ld,
    output logic                busy,
    output logic                done
);

    localparam int NUM_ITEMS   = NUM_DACS + NUM_BIAS;
    localparam int ITEM_W      = $clog2(NUM_ITEMS);
    localparam int SH_W        = (DAC_W > BIAS_W) ? DAC_W : BIAS_W;
    localparam int BIT_W       = $clog2(SH_W);
    localparam int DAC_BASE    = 20;
    localparam int DAC_STRIDE  = 2;
    localparam int BIAS_BASE   = 112;
    localparam int BIAS_STRIDE = 4;
    localparam int LAST_IDX    = NUM_ITEMS - 1;

    localparam logic [ITEM_W-1:0] LAST_ITEM = ITEM_W'(LAST_IDX);
    localparam logic [ITEM_W-1:0] DAC_ITEMS = ITEM_W'(NUM_DACS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_LOAD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Items 0..NUM_DACS-1 are DACs; the rest are bias words walked from the
    // highest word down so that bias word 0 lands nearest the chain input.
    function automatic logic item_is_dac(input logic [ITEM_W-1:0] item);
        return (item < DAC_ITEMS);
    endfunction

    function automatic logic [6:0] item_addr(input logic [ITEM_W-1:0] item);
        logic [6:0] addr;
        if (item < DAC_ITEMS) begin
            addr = 7'(DAC_BASE + DAC_STRIDE * int'(item));
        end else begin
            addr = 7'(BIAS_BASE + BIAS_STRIDE * (LAST_IDX - int'(item)));
        end
        return addr;
    endfunction

    state_t              state_r,  state_tr_s, state_nx_s;
    logic [ITEM_W-1:0]   item_r,   item_nx_s;
    logic [DIV_W-1:0]    div_r,    div_nx_s;
    logic [DIV_W-1:0]    phase_r,  phase_nx_s;
    logic                half_r,   half_nx_s;
    logic [BIT_W-1:0]    bit_r,    bit_nx_s;
    logic [SH_W-1:0]     shift_r,  shift_nx_s;

    logic                phase_end_s;
    logic [SH_W-1:0]     dac_align_s;
    logic [SH_W-1:0]     bias_align_s;
    logic                rf_hi_unused_s;

    logic                rf_re_nx_s;
    logic [6:0]          rf_addr_nx_s;
    logic                sdata_nx_s;
    logic                sclk_nx_s;
    logic                ld_phase_s;
    logic [NUM_DACS-1:0] dac_ld_nx_s;
    logic                bias_ld_nx_s;
    logic                busy_nx_s;
    logic                done_nx_s;

    // Read data is left-aligned so the bit on the wire is always shift_r MSB.
    assign dac_align_s    = SH_W'(rf_rdata[DAC_W-1:0])  << (SH_W - DAC_W);
    assign bias_align_s   = SH_W'(rf_rdata[BIAS_W-1:0]) << (SH_W - BIAS_W);
    assign rf_hi_unused_s = ^rf_rdata[31:SH_W];
    assign phase_end_s    = (phase_r == div_r);

    // Sequencer next-state: fetch, capture, shift per bit, strobe, repeat.
    always_comb begin
        state_tr_s = state_r;
        item_nx_s  = item_r;
        div_nx_s   = div_r;
        phase_nx_s = phase_r;
        half_nx_s  = half_r;
        bit_nx_s   = bit_r;
        shift_nx_s = shift_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_tr_s = ST_FETCH;
                    item_nx_s  = {ITEM_W{1'b0}};
                    div_nx_s   = div;
                end else begin
                    state_tr_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_tr_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (item_is_dac(item_r)) begin
                    shift_nx_s = dac_align_s;
                    bit_nx_s   = BIT_W'(DAC_W - 1);
                end else begin
                    shift_nx_s = bias_align_s;
                    bit_nx_s   = BIT_W'(BIAS_W - 1);
                end
                phase_nx_s = {DIV_W{1'b0}};
                half_nx_s  = 1'b0;
                state_tr_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!phase_end_s) begin
                    phase_nx_s = phase_r + DIV_W'(1);
                end else begin
                    phase_nx_s = {DIV_W{1'b0}};
                    half_nx_s  = 1'b0;
                    if (!half_r) begin
                        half_nx_s = 1'b1;
                    end else if (bit_r != {BIT_W{1'b0}}) begin
                        // sclk falling: advance to the next bit
                        bit_nx_s   = bit_r - BIT_W'(1);
                        shift_nx_s = shift_r << 1;
                    end else if (item_is_dac(item_r) || (item_r == LAST_ITEM)) begin
                        state_tr_s = ST_LOAD;
                    end else begin
                        // bias words run back-to-back without a strobe
                        item_nx_s  = item_r + ITEM_W'(1);
                        state_tr_s = ST_FETCH;
                    end
                end
            end
            ST_LOAD: begin
                if (!phase_end_s) begin
                    phase_nx_s = phase_r + DIV_W'(1);
                end else begin
                    phase_nx_s = {DIV_W{1'b0}};
                    if (!half_r) begin
                        half_nx_s = 1'b1;
                    end else if (item_r == LAST_ITEM) begin
                        state_tr_s = ST_DONE;
                    end else begin
                        item_nx_s  = item_r + ITEM_W'(1);
                        state_tr_s = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_tr_s = ST_IDLE;
            end
            default: begin
                state_tr_s = ST_IDLE;
            end
        endcase
        state_nx_s = (abort && (state_r != ST_IDLE)) ? ST_IDLE : state_tr_s;
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        rf_re_nx_s   = (state_nx_s == ST_FETCH);
        rf_addr_nx_s = 7'd0;
        sdata_nx_s   = 1'b0;
        sclk_nx_s    = 1'b0;
        ld_phase_s   = (state_nx_s == ST_LOAD) && !half_nx_s;
        dac_ld_nx_s  = {NUM_DACS{1'b0}};
        bias_ld_nx_s = 1'b0;
        busy_nx_s    = (state_nx_s != ST_IDLE);
        done_nx_s    = (state_nx_s == ST_DONE);
        if (rf_re_nx_s) begin
            rf_addr_nx_s = item_addr(item_nx_s);
        end else begin
            rf_addr_nx_s = 7'd0;
        end
        if (state_nx_s == ST_SHIFT) begin
            sdata_nx_s = shift_nx_s[SH_W-1];
            sclk_nx_s  = half_nx_s;
        end else begin
            sdata_nx_s = 1'b0;
            sclk_nx_s  = 1'b0;
        end
        if (ld_phase_s && item_is_dac(item_nx_s)) begin
            dac_ld_nx_s = NUM_DACS'(1) << item_nx_s;
        end else if (ld_phase_s) begin
            bias_ld_nx_s = 1'b1;
        end else begin
            dac_ld_nx_s  = {NUM_DACS{1'b0}};
            bias_ld_nx_s = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            item_r  <= {ITEM_W{1'b0}};
            div_r   <= {DIV_W{1'b0}};
            phase_r <= {DIV_W{1'b0}};
            half_r  <= 1'b0;
            bit_r   <= {BIT_W{1'b0}};
            shift_r <= {SH_W{1'b0}};
            rf_re   <= 1'b0;
            rf_addr <= 7'd0;
            sdata   <= 1'b0;
            sclk    <= 1'b0;
            dac_ld  <= {NUM_DACS{1'b0}};
            bias_ld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            item_r  <= item_nx_s;
            div_r   <= div_nx_s;
            phase_r <= phase_nx_s;
            half_r  <= half_nx_s;
            bit_r   <= bit_nx_s;
            shift_r <= shift_nx_s;
            rf_re   <= rf_re_nx_s;
            rf_addr <= rf_addr_nx_s;
            sdata   <= sdata_nx_s;
            sclk    <= sclk_nx_s;
            dac_ld  <= dac_ld_nx_s;
            bias_ld <= bias_ld_nx_s;
            busy    <= busy_nx_s;
            done    <= done_nx_s;
        end
    end

endmodule
